// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline-register widths, ID/EX control layout and
// pack/unpack helpers for the ID/EX, EX/MEM and MEM/WB stage vectors.
package pipe_pkg;
   localparam int CTRL_W = 10;
   localparam int DATA_W = 165;
   localparam int OCC_W  = 2;
   localparam int IDEX_REGWRITE    = 9;
   localparam int IDEX_RESULTSRC   = 7;
   localparam int IDEX_RESULTSRC_W = 2;
   localparam int IDEX_MEMWRITE    = 6;
   localparam int IDEX_JUMP        = 5;
   localparam int IDEX_BRANCH      = 4;
   localparam int IDEX_ALUCTRL     = 1;
   localparam int IDEX_ALUCTRL_W   = 3;
   localparam int IDEX_ALUSRC      = 0;
   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
      logic       jump;
      logic       branch;
      logic [2:0] alu_control;
      logic       alu_src;
   } idex_ctrl_t;
   typedef struct packed {
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] imm_ext;
      logic [31:0] pc_plus4;
   } idex_data_t;
   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
   } exmem_ctrl_t;
   typedef struct packed {
      logic [31:0] alu_result;
      logic [31:0] write_data;
      logic [4:0]  rd;
      logic [31:0] pc_plus4;
   } exmem_data_t;
   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
   } memwb_ctrl_t;
   typedef struct packed {
      logic [31:0] alu_result;
      logic [31:0] read_data;
      logic [4:0]  rd;
      logic [31:0] pc_plus4;
   } memwb_data_t;
   localparam int EXMEM_CTRL_W = $bits(exmem_ctrl_t);
   localparam int EXMEM_DATA_W = $bits(exmem_data_t);
   localparam int MEMWB_CTRL_W = $bits(memwb_ctrl_t);
   localparam int MEMWB_DATA_W = $bits(memwb_data_t);
   function automatic logic [CTRL_W-1:0] pack_idex_ctrl(input idex_ctrl_t c);
      return c;
   endfunction
   function automatic idex_ctrl_t unpack_idex_ctrl(input logic [CTRL_W-1:0] v);
      return idex_ctrl_t'(v);
   endfunction
   function automatic logic [DATA_W-1:0] pack_idex_data(input idex_data_t d);
      return d;
   endfunction
   function automatic idex_data_t unpack_idex_data(input logic [DATA_W-1:0] v);
      return idex_data_t'(v);
   endfunction
   function automatic logic [EXMEM_CTRL_W-1:0] pack_exmem_ctrl(input exmem_ctrl_t c);
      return c;
   endfunction
   function automatic exmem_ctrl_t unpack_exmem_ctrl(input logic [EXMEM_CTRL_W-1:0] v);
      return exmem_ctrl_t'(v);
   endfunction
   function automatic logic [EXMEM_DATA_W-1:0] pack_exmem_data(input exmem_data_t d);
      return d;
   endfunction
   function automatic exmem_data_t unpack_exmem_data(input logic [EXMEM_DATA_W-1:0] v);
      return exmem_data_t'(v);
   endfunction
   function automatic logic [MEMWB_CTRL_W-1:0] pack_memwb_ctrl(input memwb_ctrl_t c);
      return c;
   endfunction
   function automatic memwb_ctrl_t unpack_memwb_ctrl(input logic [MEMWB_CTRL_W-1:0] v);
      return memwb_ctrl_t'(v);
   endfunction
   function automatic logic [MEMWB_DATA_W-1:0] pack_memwb_data(input memwb_data_t d);
      return d;
   endfunction
   function automatic memwb_data_t unpack_memwb_data(input logic [MEMWB_DATA_W-1:0] v);
      return memwb_data_t'(v);
   endfunction
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid/ready stage boundary plus flush and occupancy.
interface pipe_stage_reg_if import pipe_pkg::*; #(
   parameter int CTRL_W = pipe_pkg::CTRL_W,
   parameter int DATA_W = pipe_pkg::DATA_W
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic [OCC_W-1:0]  occupancy;
   modport master (
      output flush, in_valid, in_ctrl, in_data, out_ready,
      input  in_ready, out_valid, out_ctrl, out_data, occupancy
   );
   modport slave (
      input  flush, in_valid, in_ctrl, in_data, out_ready,
      output in_ready, out_valid, out_ctrl, out_data, occupancy
   );
endinterface

// File: rtl/pipe_slot.sv
// pipe_slot: one valid+ctrl+data register; clear makes it a bubble with ctrl zeroed.
module pipe_slot #(
   parameter int CTRL_W   = pipe_pkg::CTRL_W,
   parameter int DATA_W   = pipe_pkg::DATA_W,
   parameter bit CLR_DATA = 1'b0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              load,
   input  logic              clear,
   input  logic [CTRL_W-1:0] d_ctrl,
   input  logic [DATA_W-1:0] d_data,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         valid <= 1'b0;
         ctrl  <= '0;
         data  <= '0;
      end else if (clear) begin
         valid <= 1'b0;
         ctrl  <= '0;
         if (CLR_DATA) data <= '0;
      end else if (load) begin
         valid <= 1'b1;
         ctrl  <= d_ctrl;
         data  <= d_data;
      end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with optional 2-entry
// skid buffer (registered in_ready) and synchronous flush.
module pipe_stage_reg import pipe_pkg::*; #(
   parameter int CTRL_W         = pipe_pkg::CTRL_W,
   parameter int DATA_W         = pipe_pkg::DATA_W,
   parameter bit SKID           = 1'b1,
   parameter bit FLUSH_CLR_DATA = 1'b0
) (
   input logic             CLK,
   input logic             RST,
   pipe_stage_reg_if.slave bus
);
   logic              acc, m_take;
   logic              m_load, m_clear, s_load, s_clear;
   logic              m_valid, s_valid;
   logic [CTRL_W-1:0] s_ctrl;
   logic [DATA_W-1:0] s_data;
   assign bus.in_ready  = SKID ? !s_valid : (!m_valid || bus.out_ready);
   assign acc           = bus.in_valid && bus.in_ready;
   assign m_take        = !m_valid || bus.out_ready;
   assign bus.out_valid = m_valid;
   assign bus.occupancy = OCC_W'(m_valid) + OCC_W'(s_valid);
   // M refills from S first to keep FIFO order; S only catches what M cannot take
   always_comb begin
      m_load  = !bus.flush && m_take && (s_valid || acc);
      m_clear = bus.flush || (m_take && !s_valid && !acc);
      s_load  = !bus.flush && acc && !(m_take && !s_valid);
      s_clear = bus.flush || (m_take && s_valid && !acc);
   end
   pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLR_DATA(FLUSH_CLR_DATA)) u_m (
      .CLK(CLK), .RST(RST), .load(m_load), .clear(m_clear),
      .d_ctrl(s_valid ? s_ctrl : bus.in_ctrl),
      .d_data(s_valid ? s_data : bus.in_data),
      .valid(m_valid), .ctrl(bus.out_ctrl), .data(bus.out_data)
   );
   if (SKID) begin : g_skid
      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLR_DATA(FLUSH_CLR_DATA)) u_s (
         .CLK(CLK), .RST(RST), .load(s_load), .clear(s_clear),
         .d_ctrl(bus.in_ctrl), .d_data(bus.in_data),
         .valid(s_valid), .ctrl(s_ctrl), .data(s_data)
      );
   end else begin : g_noskid
      assign s_valid = 1'b0;
      assign s_ctrl  = '0;
      assign s_data  = '0;
   end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: three stage configurations driven in parallel, each checked
// against a queue model; a directed vector table targets the SKID=1 instance.
module tb_pipe_stage_reg;
   import pipe_pkg::*;
   typedef logic [DATA_W-1:0] w_t;
   typedef struct packed { logic [CTRL_W-1:0] ctrl; logic [DATA_W-1:0] data; } ent_t;
   typedef struct {
      logic iv; logic [31:0] d; logic [CTRL_W-1:0] c; logic ordy; logic fl;
      logic ev; logic [31:0] ed; logic [CTRL_W-1:0] ec; logic [1:0] eo; logic er;
   } vec_t;
   logic              CLK = 1'b0;
   logic              RST = 1'b0;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              out_ready = 1'b0;
   logic [CTRL_W-1:0] in_ctrl = '0;
   logic [DATA_W-1:0] in_data = '0;
   int n_chk = 0;
   int n_pass = 0;
   always #5 CLK = ~CLK;
   // u[0]: SKID=1 keep data, u[1]: SKID=0 keep data, u[2]: SKID=1 clear data
   for (genvar g = 0; g < 3; g++) begin : u
      localparam bit SK = (g != 1);
      localparam bit CL = (g == 2);
      pipe_stage_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) bus ();
      ent_t q[$];
      int qn = 0;
      logic [CTRL_W-1:0] fc = '0;
      logic [DATA_W-1:0] fd = '0;
      logic [DATA_W-1:0] md = '0;
      assign bus.flush     = flush;
      assign bus.in_valid  = in_valid;
      assign bus.in_ctrl   = in_ctrl;
      assign bus.in_data   = in_data;
      assign bus.out_ready = out_ready;
      pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(SK), .FLUSH_CLR_DATA(CL)) dut (
         .CLK(CLK), .RST(RST), .bus(bus.slave)
      );
      always @(posedge CLK or negedge RST) begin : model
         logic rdy;
         logic [DATA_W-1:0] nd;
         if (!RST) begin
            q.delete();
            md <= '0;
            qn <= 0;
            fc <= '0;
            fd <= '0;
         end else begin
            rdy = SK ? (q.size() < 2) : (q.size() == 0 || out_ready);
            nd = q.size() > 0 ? q[0].data : md;
            if (flush) q.delete();
            else begin
               if (q.size() > 0 && out_ready) void'(q.pop_front());
               if (in_valid && rdy) q.push_back('{ctrl: in_ctrl, data: in_data});
            end
            if (q.size() == 0 && CL) nd = '0;
            md <= nd;
            qn <= q.size();
            fc <= q.size() > 0 ? q[0].ctrl : '0;
            fd <= q.size() > 0 ? q[0].data : nd;
         end
      end
   end
   task automatic cmp(input string nm, input int g, input w_t act, input w_t exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s #%0d: got %0h expected %0h", nm, g, act, exp);
   endtask
   task automatic chk_one(input int g, input bit sk, input logic v, input logic r,
                          input logic [CTRL_W-1:0] c, input w_t d, input logic [1:0] o,
                          input int qn, input logic [CTRL_W-1:0] fc, input w_t fd);
      cmp("model out_valid", g, w_t'(v), w_t'(qn != 0));
      cmp("model out_ctrl", g, w_t'(c), w_t'(fc));
      cmp("model out_data", g, d, fd);
      cmp("model occupancy", g, w_t'(o), w_t'(qn));
      cmp("model in_ready", g, w_t'(r), w_t'(sk ? (qn < 2) : (qn == 0 || out_ready)));
   endtask
   task automatic chk_all();
      chk_one(0, 1'b1, u[0].bus.out_valid, u[0].bus.in_ready, u[0].bus.out_ctrl,
              u[0].bus.out_data, u[0].bus.occupancy, u[0].qn, u[0].fc, u[0].fd);
      chk_one(1, 1'b0, u[1].bus.out_valid, u[1].bus.in_ready, u[1].bus.out_ctrl,
              u[1].bus.out_data, u[1].bus.occupancy, u[1].qn, u[1].fc, u[1].fd);
      chk_one(2, 1'b1, u[2].bus.out_valid, u[2].bus.in_ready, u[2].bus.out_ctrl,
              u[2].bus.out_data, u[2].bus.occupancy, u[2].qn, u[2].fc, u[2].fd);
   endtask
   task automatic step();
      @(posedge CLK);
      @(negedge CLK);
   endtask
   function automatic vec_t mk(input int iv, input int d, input int ordy, input int fl,
                               input int ev, input int ed, input int eo, input int er);
      vec_t v;
      v.iv = iv != 0; v.d = d; v.c = iv != 0 ? CTRL_W'(d) : '1;
      v.ordy = ordy != 0; v.fl = fl != 0;
      v.ev = ev != 0; v.ed = ed; v.ec = ev != 0 ? CTRL_W'(ed) : '0;
      v.eo = 2'(eo); v.er = er != 0;
      return v;
   endfunction
   task automatic chk_zero(input string nm);
      cmp({nm, " out_valid"}, 0, w_t'(u[0].bus.out_valid), '0);
      cmp({nm, " out_ctrl"}, 0, w_t'(u[0].bus.out_ctrl), '0);
      cmp({nm, " out_data"}, 0, u[0].bus.out_data, '0);
      cmp({nm, " occupancy"}, 0, w_t'(u[0].bus.occupancy), '0);
      cmp({nm, " in_ready"}, 0, w_t'(u[0].bus.in_ready), w_t'(1));
   endtask
   initial begin
      vec_t tv[$];
      for (int d = 1; d <= 8; d++) tv.push_back(mk(1, d, 1, 0, 1, d, 1, 1));
      tv.push_back(mk(0, 0, 1, 0, 0, 8, 0, 1));
      tv.push_back(mk(1, 1, 1, 0, 1, 1, 1, 1));
      tv.push_back(mk(1, 2, 0, 0, 1, 1, 2, 0));
      tv.push_back(mk(1, 3, 0, 0, 1, 1, 2, 0));
      tv.push_back(mk(1, 3, 1, 0, 1, 2, 1, 1));
      tv.push_back(mk(1, 3, 0, 0, 1, 2, 2, 0));
      tv.push_back(mk(1, 4, 1, 0, 1, 3, 1, 1));
      tv.push_back(mk(1, 4, 1, 0, 1, 4, 1, 1));
      tv.push_back(mk(0, 0, 1, 0, 0, 4, 0, 1));
      tv.push_back(mk(1, 5, 0, 0, 1, 5, 1, 1));
      tv.push_back(mk(1, 6, 0, 0, 1, 5, 2, 0));
      tv.push_back(mk(1, 9, 0, 1, 0, 5, 0, 1));
      tv.push_back(mk(0, 0, 1, 0, 0, 5, 0, 1));
      tv.push_back(mk(1, 7, 0, 0, 1, 7, 1, 1));
      tv.push_back(mk(1, 9, 0, 1, 0, 7, 0, 1));
      tv.push_back(mk(0, 0, 1, 0, 0, 7, 0, 1));
      tv.push_back(mk(1, 10, 1, 0, 1, 10, 1, 1));
      tv.push_back(mk(0, 0, 1, 1, 0, 10, 0, 1));
      #12;
      chk_zero("reset");
      chk_all();
      @(negedge CLK);
      RST = 1'b1;
      foreach (tv[i]) begin
         in_valid = tv[i].iv; in_data = w_t'(tv[i].d); in_ctrl = tv[i].c;
         out_ready = tv[i].ordy; flush = tv[i].fl;
         step();
         cmp("tbl out_valid", i, w_t'(u[0].bus.out_valid), w_t'(tv[i].ev));
         cmp("tbl out_ctrl", i, w_t'(u[0].bus.out_ctrl), w_t'(tv[i].ec));
         cmp("tbl out_data", i, u[0].bus.out_data, w_t'(tv[i].ed));
         cmp("tbl occupancy", i, w_t'(u[0].bus.occupancy), w_t'(tv[i].eo));
         cmp("tbl in_ready", i, w_t'(u[0].bus.in_ready), w_t'(tv[i].er));
         chk_all();
      end
      flush = 1'b0;
      in_valid = 1'b0; in_ctrl = '1; out_ready = 1'b1;
      step();
      cmp("bubble keep data", 0, u[0].bus.out_data, w_t'(10));
      cmp("bubble clr data", 2, u[2].bus.out_data, '0);
      cmp("bubble clr ctrl", 2, w_t'(u[2].bus.out_ctrl), '0);
      in_valid = 1'b1; out_ready = 1'b0;
      in_data = w_t'(11); in_ctrl = CTRL_W'(11);
      step();
      in_data = w_t'(12); in_ctrl = CTRL_W'(12);
      step();
      cmp("pre-reset occupancy", 0, w_t'(u[0].bus.occupancy), w_t'(2));
      #2 RST = 1'b0;
      #1 chk_zero("async reset");
      chk_all();
      repeat (3) begin
         step();
         chk_zero("held reset");
      end
      RST = 1'b1;
      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom % 4) != 0;
         in_data = w_t'({$urandom, $urandom});
         in_ctrl = CTRL_W'($urandom);
         out_ready = i < 60 ? i[0] : (($urandom % 3) != 0);
         flush = ($urandom % 20) == 0;
         step();
         chk_all();
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
